instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 SHALL have parameter DEPTH, default 256, number of writable words from start_addr (at most 2**ADDR_W).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 start_addr  input  ADDR_W  first write address, sampled with start.
REQ-007 in_valid  input  1  field bundle valid.
REQ-008 in_ready  output  1  encoder can accept a bundle.
REQ-009 in_last  input  1  marks the final bundle of the session.
REQ-010 op  input  5  opcode field.
REQ-011 mode  input  2  addressing-mode field.
REQ-012 src  input  5  source-register field.
REQ-013 dst  input  5  destination-register field.
REQ-014 litsrc  input  32  literal/source field.
REQ-015 imem_we  output  1  instruction-memory write strobe.
REQ-016 imem_addr  output  ADDR_W  write address.
REQ-017 imem_wdata  output  49  packed instruction word.
REQ-018 done  output  1  session finished, level.
REQ-019 ovf  output  1  memory filled before in_last.
REQ-020 n_branch  output  16  branch words written, saturating.
REQ-021 n_store  output  16  store words written, saturating.

Function
REQ-022 Packing SHALL be {op, mode, src, dst, litsrc} into bits [48:44], [43:42], [41:37], [36:32], [31:0].
REQ-023 FSM states SHALL be IDLE, LOAD, DONE.
- IDLE/DONE --start--> LOAD.
- LOAD --in_last accepted, or word count reaches DEPTH--> DONE.
REQ-024 start in LOAD SHALL be ignored.
REQ-025 On start: word pointer <= start_addr; count, n_branch, n_store, ovf, done <= 0.
REQ-026 in_ready SHALL be 1 only in LOAD with count < DEPTH.
REQ-027 in_ready SHALL not depend on in_valid.
REQ-028 A bundle is accepted when in_valid && in_ready.
REQ-029 Accept latency SHALL be 1: imem_we=1 in the cycle after acceptance, with imem_addr = pointer and imem_wdata = the packed word.
REQ-030 After a write, the pointer SHALL increment.
REQ-031 imem_addr SHALL wrap modulo 2**ADDR_W.
REQ-032 imem_we SHALL be 0 in every cycle without a preceding acceptance; back-to-back accepts SHALL give back-to-back writes.
REQ-033 For each word written, op in {5'h10, 5'h11, 5'h12} SHALL increment n_branch, and op == 5'h02 SHALL increment n_store; both SHALL saturate at 16'hFFFF.
REQ-034 Count reaching DEPTH SHALL enter DONE, and SHALL also set ovf=1 if in_last was not asserted on that beat.
REQ-035 Count reaching DEPTH on the in_last beat SHALL leave ovf=0.
REQ-036 done SHALL assert on the cycle of the final imem_we and SHALL hold until the next start or rst.
REQ-037 A start coincident with the final write in DONE SHALL be impossible; a start in DONE SHALL take effect after the final write completes.

Reset
REQ-038 rst=1 SHALL immediately force IDLE and set in_ready, imem_we, done, ovf = 0, imem_addr = 0, imem_wdata = 0, n_branch = 0 and n_store = 0.
REQ-039 Assertion mid-session SHALL abort it, with no write issued for a pending accepted bundle.

Configuration
REQ-040 SHALL recognise macro INSTR_ENC_OPCHECK_EN.
REQ-041 When INSTR_ENC_OPCHECK_EN is defined, an accepted bundle with op > 5'h12 SHALL be consumed without a write or pointer increment and SHALL set sticky output bad_op (1 bit, cleared by start/rst).
REQ-042 When INSTR_ENC_OPCHECK_EN is undefined, bad_op SHALL be absent and every opcode SHALL be written.
REQ-043 With the check on, an illegal in_last beat SHALL still end the session, and done SHALL assert the cycle after acceptance.

Structure
REQ-044 Shared package isa_pkg SHALL hold:
- INSTR_W=49 and the field MSB/LSB constants;
- OP_STORE=5'h02, OP_BR0..OP_BR2=5'h10..5'h12 and OP_MAX=5'h12;
- the FSM state enum.
REQ-045 Combinational sub-module instr_pack SHALL perform field packing and the is_branch/is_store/is_legal classification; instr_encoder SHALL instantiate it once.

Verification
REQ-046 start, start_addr=8'h10, then 3 bundles (op=02; op=10; op=05, last) -> writes at 10, 11, 12; n_store=1; n_branch=1; done=1; ovf=0.
REQ-047 op=1F, mode=3, src=1F, dst=00, litsrc=DEADBEEF -> imem_wdata = 49'h1_FFE0_DEAD_BEEF.
REQ-048 DEPTH=4, 6 bundles offered without last -> 4 writes; in_ready=0 after the 4th accept; ovf=1; done=1.
REQ-049 start_addr=8'hFE, 3 bundles -> addresses FE, FF, 00.
REQ-050 rst pulsed the cycle after an accept -> no imem_we; all outputs 0; state IDLE.
REQ-051 With INSTR_ENC_OPCHECK_EN, bundles op=13 then op=01 (last) -> a single write of op=01 at start_addr; bad_op=1.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder.
// Holds the packed instruction width, field bit positions, the opcode
// constants used for classification, the encoder FSM state type and a
// saturating counter helper.
package isa_pkg;

    localparam int INSTR_W  = 49;

    localparam int OP_MSB   = 48;
    localparam int OP_LSB   = 44;
    localparam int MODE_MSB = 43;
    localparam int MODE_LSB = 42;
    localparam int SRC_MSB  = 41;
    localparam int SRC_LSB  = 37;
    localparam int DST_MSB  = 36;
    localparam int DST_LSB  = 32;
    localparam int LIT_MSB  = 31;
    localparam int LIT_LSB  = 0;

    localparam logic [4:0] OP_STORE = 5'h02;
    localparam logic [4:0] OP_BR0   = 5'h10;
    localparam logic [4:0] OP_BR1   = 5'h11;
    localparam logic [4:0] OP_BR2   = 5'h12;
    localparam logic [4:0] OP_MAX   = 5'h12;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        DONE = 2'b10
    } enc_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer and opcode classifier.
// Ports:
//   op, mode, src, dst, litsrc : instruction fields
//   word                       : packed {op, mode, src, dst, litsrc}
//   is_branch                  : op is one of the three branch opcodes
//   is_store                   : op is the store opcode
//   is_legal                   : op is within the defined opcode range
module instr_pack
    import isa_pkg::*;
(
    input  logic [4:0]         op,
    input  logic [1:0]         mode,
    input  logic [4:0]         src,
    input  logic [4:0]         dst,
    input  logic [31:0]        litsrc,
    output logic [INSTR_W-1:0] word,
    output logic               is_branch,
    output logic               is_store,
    output logic               is_legal
);

    // Place each field at its fixed bit position in the instruction word.
    always_comb begin
        word                   = '0;
        word[OP_MSB:OP_LSB]     = op;
        word[MODE_MSB:MODE_LSB] = mode;
        word[SRC_MSB:SRC_LSB]   = src;
        word[DST_MSB:DST_LSB]   = dst;
        word[LIT_MSB:LIT_LSB]   = litsrc;
    end

    // Classify the opcode for the statistics counters and legality check.
    always_comb begin
        is_branch = 1'b0;
        is_store  = 1'b0;
        is_legal  = 1'b0;
        case (op)
            OP_BR0, OP_BR1, OP_BR2: is_branch = 1'b1;
            OP_STORE:               is_store  = 1'b1;
            default:                is_branch = 1'b0;
        endcase
        if (op <= OP_MAX) begin
            is_legal = 1'b1;
        end else begin
            is_legal = 1'b0;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field bundles over a valid/ready handshake
// during a load session, packs each into a 49-bit word and writes it to
// instruction memory at consecutive (wrapping) addresses from start_addr.
// Optional feature macro: INSTR_ENC_OPCHECK_EN -- drop opcodes above OP_MAX
// without writing them and flag them on the sticky bad_op output.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, start_addr        : begin a session at the given address
//   in_valid/in_ready/in_last: bundle handshake, last marks session end
//   op, mode, src, dst, litsrc: instruction fields
//   imem_we/addr/wdata       : registered memory write port
//   done, ovf                : session finished / memory filled before last
//   n_branch, n_store        : saturating counts of words written
//   bad_op (optional)        : illegal opcode seen this session
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [4:0]         op,
    input  logic [1:0]         mode,
    input  logic [4:0]         src,
    input  logic [4:0]         dst,
    input  logic [31:0]        litsrc,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               done,
    output logic               ovf,
    output logic [15:0]        n_branch,
    output logic [15:0]        n_store
`ifdef INSTR_ENC_OPCHECK_EN
    ,
    output logic               bad_op
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    enc_state_e          state_r;
    enc_state_e          state_nxt_s;
    logic [ADDR_W-1:0]   ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                imem_we_r;
    logic [ADDR_W-1:0]   imem_addr_r;
    logic [INSTR_W-1:0]  imem_wdata_r;
    logic                done_r;
    logic                ovf_r;
    logic [15:0]         n_branch_r;
    logic [15:0]         n_store_r;

    logic [INSTR_W-1:0]  word_s;
    logic                is_branch_s;
    logic                is_store_s;
    logic                is_legal_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                write_s;
    logic                last_fill_s;
    logic                finish_s;
    logic                start_s;

    instr_pack u_pack (
        .op        (op),
        .mode      (mode),
        .src       (src),
        .dst       (dst),
        .litsrc    (litsrc),
        .word      (word_s),
        .is_branch (is_branch_s),
        .is_store  (is_store_s),
        .is_legal  (is_legal_s)
    );

    // Ready depends only on state and fill level, never on in_valid.
    assign in_ready_s = (state_r == LOAD) && (count_r < DEPTH_C);
    assign accept_s   = in_valid && in_ready_s;

`ifdef INSTR_ENC_OPCHECK_EN
    logic bad_op_r;
    assign write_s = accept_s && is_legal_s;
    assign bad_op  = bad_op_r;
`else
    // Legality is only consumed when opcode checking is compiled in.
    logic unused_legal_s;
    assign unused_legal_s = is_legal_s;
    assign write_s        = accept_s;
`endif

    // The write that brings the count up to DEPTH fills the memory window.
    assign last_fill_s = write_s && (count_r == (DEPTH_C - CNT_W'(1)));
    assign finish_s    = accept_s && (in_last || last_fill_s);
    // A start during LOAD is ignored.
    assign start_s     = start && (state_r != LOAD);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (finish_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Session datapath: pointer, fill count, write port, status and counters.
    // done is set on the accept edge so it rises together with the final write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r        <= '0;
            count_r      <= '0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= '0;
            done_r       <= 1'b0;
            ovf_r        <= 1'b0;
            n_branch_r   <= 16'd0;
            n_store_r    <= 16'd0;
`ifdef INSTR_ENC_OPCHECK_EN
            bad_op_r     <= 1'b0;
`endif
        end else begin
            imem_we_r <= 1'b0;
            if (start_s) begin
                ptr_r      <= start_addr;
                count_r    <= '0;
                done_r     <= 1'b0;
                ovf_r      <= 1'b0;
                n_branch_r <= 16'd0;
                n_store_r  <= 16'd0;
`ifdef INSTR_ENC_OPCHECK_EN
                bad_op_r   <= 1'b0;
`endif
            end else if (accept_s) begin
                if (write_s) begin
                    imem_we_r    <= 1'b1;
                    imem_addr_r  <= ptr_r;
                    imem_wdata_r <= word_s;
                    ptr_r        <= ptr_r + ADDR_W'(1);
                    count_r      <= count_r + CNT_W'(1);
                    if (is_branch_s) begin
                        n_branch_r <= sat_inc16(n_branch_r);
                    end
                    if (is_store_s) begin
                        n_store_r <= sat_inc16(n_store_r);
                    end
                end
`ifdef INSTR_ENC_OPCHECK_EN
                if (!is_legal_s) begin
                    bad_op_r <= 1'b1;
                end
`endif
                if (finish_s) begin
                    done_r <= 1'b1;
                    ovf_r  <= last_fill_s && !in_last;
                end
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign done       = done_r;
    assign ovf        = ovf_r;
    assign n_branch   = n_branch_r;
    assign n_store    = n_store_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH reduced to 4 so the
// memory-full path is reachable). A session-level reference model predicts
// ready, writes, status and counters every cycle.
module tb_instr_encoder;
    import isa_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [ADDR_W-1:0]  start_addr = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_last = 1'b0;
    logic [4:0]         op = '0;
    logic [1:0]         mode = '0;
    logic [4:0]         src = '0;
    logic [4:0]         dst = '0;
    logic [31:0]        litsrc = '0;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [48:0]        imem_wdata;
    logic               done;
    logic               ovf;
    logic [15:0]        n_branch;
    logic [15:0]        n_store;
`ifdef INSTR_ENC_OPCHECK_EN
    logic               bad_op;
`endif

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .op         (op),
        .mode       (mode),
        .src        (src),
        .dst        (dst),
        .litsrc     (litsrc),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .done       (done),
        .ovf        (ovf),
        .n_branch   (n_branch),
        .n_store    (n_store)
`ifdef INSTR_ENC_OPCHECK_EN
        ,
        .bad_op     (bad_op)
`endif
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: session open flag, next address, words written, stats.
    bit m_sess = 1'b0;
    int m_ptr  = 0;
    int m_cnt  = 0;
    int m_nb   = 0;
    int m_ns   = 0;
    bit m_done = 1'b0;
    bit m_ovf  = 1'b0;
    bit m_bad  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit op_legal(input logic [4:0] o);
`ifdef INSTR_ENC_OPCHECK_EN
        return (o <= 5'h12);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_sess = 1'b0; m_ptr = 0; m_cnt = 0; m_nb = 0; m_ns = 0;
        m_done = 1'b0; m_ovf = 1'b0; m_bad = 1'b0;
    endtask

    // One clock cycle: drive inputs, check ready, clock, check results.
    // Called at posedge+1 and returns at the next posedge+1.
    task automatic cyc(input bit s, input logic [7:0] sa, input bit v, input bit l,
                       input logic [4:0] o, input logic [1:0] md, input logic [4:0] sr,
                       input logic [4:0] ds, input logic [31:0] lt);
        bit          ready_e;
        bit          acc;
        bit          wr;
        int          addr_e;
        logic [48:0] word_e;
        start = s; start_addr = sa; in_valid = v; in_last = l;
        op = o; mode = md; src = sr; dst = ds; litsrc = lt;
        #1;
        ready_e = m_sess && (m_cnt < DEPTH);
        chk("in_ready", 64'(in_ready), 64'(ready_e));
        acc    = v && ready_e;
        wr     = acc && op_legal(o);
        addr_e = m_ptr;
        word_e = {o, md, sr, ds, lt};
        @(posedge clk);
        #1;
        if (s && !m_sess) begin
            m_sess = 1'b1; m_ptr = sa; m_cnt = 0; m_nb = 0; m_ns = 0;
            m_done = 1'b0; m_ovf = 1'b0; m_bad = 1'b0;
        end else if (acc) begin
            if (wr) begin
                m_ptr = (m_ptr + 1) % 256;
                m_cnt = m_cnt + 1;
                if ((o == 5'h10 || o == 5'h11 || o == 5'h12) && m_nb < 65535) m_nb++;
                if (o == 5'h02 && m_ns < 65535) m_ns++;
            end else begin
                m_bad = 1'b1;
            end
            if (l || m_cnt == DEPTH) begin
                m_sess = 1'b0;
                m_done = 1'b1;
                m_ovf  = !l;
            end
        end
        chk("imem_we", 64'(imem_we), 64'(wr));
        if (wr) begin
            chk("imem_addr", 64'(imem_addr), 64'(addr_e));
            chk("imem_wdata", 64'(imem_wdata), 64'(word_e));
        end
        chk("done", 64'(done), 64'(m_done));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("n_branch", 64'(n_branch), 64'(m_nb));
        chk("n_store", 64'(n_store), 64'(m_ns));
`ifdef INSTR_ENC_OPCHECK_EN
        chk("bad_op", 64'(bad_op), 64'(m_bad));
`endif
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_we"}, 64'(imem_we), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
        chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_nbr"}, 64'(n_branch), 64'd0);
        chk({tag, "_nst"}, 64'(n_store), 64'd0);
        chk({tag, "_state"}, 64'(dut.state_r), 64'(IDLE));
    endtask

    initial begin
        logic [7:0] exp_addr [3];
        bit         s_r;
        bit         v_r;
        bit         l_r;
        logic [4:0] o_r;

        // Power-on reset.
        #1 rst = 1'b1;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Three-bundle session from 0x10: store, branch, other (last).
        cyc(1'b1, 8'h10, 1'b0, 1'b0, 5'h00, 2'd0, 5'd0, 5'd0, 32'h0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 5'h02, 2'd1, 5'd3, 5'd4, 32'h1111_0001);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 5'h10, 2'd2, 5'd5, 5'd6, 32'h2222_0002);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 5'h05, 2'd3, 5'd7, 5'd8, 32'h3333_0003);
        chk("t1_addr", 64'(imem_addr), 64'h12);
        chk("t1_nstore", 64'(n_store), 64'd1);
        chk("t1_nbranch", 64'(n_branch), 64'd1);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_ovf", 64'(ovf), 64'd0);

        // Start in the cycle the final write is visible, then all-ones packing.
        cyc(1'b1, 8'h40, 1'b0, 1'b0, 5'h00, 2'd0, 5'd0, 5'd0, 32'h0);
        chk("t2_done_clr", 64'(done), 64'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 5'h1F, 2'd3, 5'h1F, 5'h00, 32'hDEAD_BEEF);
`ifndef INSTR_ENC_OPCHECK_EN
        chk("t2_word", 64'(imem_wdata), 64'h1_FFE0_DEAD_BEEF);
`endif

        // Six bundles without last: memory window fills after four.
        cyc(1'b1, 8'h20, 1'b0, 1'b0, 5'h00, 2'd0, 5'd0, 5'd0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 5'(i + 1), 2'(i), 5'(i), 5'(i + 2), 32'(i * 7));
        end
        chk("t3_ready", 64'(in_ready), 64'd0);
        chk("t3_ovf", 64'(ovf), 64'd1);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_addr", 64'(imem_addr), 64'h23);

        // Address wrap from 0xFE.
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00;
        cyc(1'b1, 8'hFE, 1'b0, 1'b0, 5'h00, 2'd0, 5'd0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1, (i == 2), 5'h01, 2'd0, 5'd1, 5'd2, 32'(i));
            chk("t4_wrap_addr", 64'(imem_addr), 64'(exp_addr[i]));
        end

        // Full-window fill that coincides with last leaves ovf clear.
        cyc(1'b1, 8'h80, 1'b0, 1'b0, 5'h00, 2'd0, 5'd0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1, (i == 3), 5'h11, 2'd1, 5'd1, 5'd1, 32'(i));
        end
        chk("t5_ovf", 64'(ovf), 64'd0);
        chk("t5_done", 64'(done), 64'd1);

        // Reset while an accepted bundle's write is on the port.
        cyc(1'b1, 8'h50, 1'b0, 1'b0, 5'h00, 2'd0, 5'd0, 5'd0, 32'h0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 5'h02, 2'd1, 5'd1, 5'd1, 32'h5);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 5'h02, 2'd0, 5'd0, 5'd0, 32'h0);
        chk("t6_no_we", 64'(imem_we), 64'd0);

`ifdef INSTR_ENC_OPCHECK_EN
        // Illegal opcode is consumed without a write and flagged.
        cyc(1'b1, 8'h30, 1'b0, 1'b0, 5'h00, 2'd0, 5'd0, 5'd0, 32'h0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 5'h13, 2'd0, 5'd0, 5'd0, 32'h0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 5'h01, 2'd0, 5'd0, 5'd0, 32'h0);
        chk("t7_addr", 64'(imem_addr), 64'h30);
        chk("t7_bad", 64'(bad_op), 64'd1);
        // Illegal last bundle still ends the session.
        cyc(1'b1, 8'h31, 1'b0, 1'b0, 5'h00, 2'd0, 5'd0, 5'd0, 32'h0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 5'h1A, 2'd0, 5'd0, 5'd0, 32'h0);
        chk("t7_done_bad_last", 64'(done), 64'd1);
`endif

        // Random sessions, including stray starts during LOAD.
        for (int sess = 0; sess < 25; sess++) begin
            cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 5'h00, 2'd0, 5'd0, 5'd0, 32'h0);
            for (int k = 0; k < 8; k++) begin
                s_r = ($urandom_range(0, 9) == 0);
                v_r = ($urandom_range(0, 9) < 7);
                l_r = ($urandom_range(0, 5) == 0);
                case ($urandom_range(0, 4))
                    0:       o_r = 5'h02;
                    1:       o_r = 5'h10;
                    2:       o_r = 5'h11;
                    3:       o_r = 5'h12;
                    default: o_r = 5'($urandom_range(0, 31));
                endcase
                cyc(s_r, 8'($urandom_range(0, 255)), v_r, l_r, o_r,
                    2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 32'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
